// File: rtl/cpu_rst_ctrl.sv
// cpu_rst_ctrl: per-channel CPU reset sequencer.
// Each channel stretches software reset requests to a minimum pulse width.
// A debug bridge can hold the CPU in reset through a GPIO level, but only
// once that level has been seen high at least once (the channel is then
// "armed"). This stops a floating or unconnected bridge from holding the
// CPU after power-up.

// Single channel: RUN / STRETCH / HELD state machine, pulse counter, arm flag.
module cpu_rst_ctrl_ch #(
    parameter int RST_CYCLES = 16,
    parameter bit BOOT_RUN   = 1'b1,
    parameter int CW         = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic dbg_run_i,
    input  logic sw_rst_req_i,
    output logic rst_cpu_o,
    output logic armed_o,
    output logic stretch_o
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STRETCH = 2'd1,
        ST_HELD    = 2'd2
    } state_e;

    // The counter runs from RST_CYCLES-1 down to 0. This gives exactly
    // RST_CYCLES cycles in STRETCH before the channel returns to RUN.
    localparam logic [CW-1:0] CNT_LOAD = CW'(RST_CYCLES - 1);
    localparam state_e        RST_ST   = BOOT_RUN ? ST_STRETCH : ST_HELD;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            armed_q, armed_d;
    logic            hold;

    // The bridge may only hold the CPU once it has shown a run level.
    assign hold    = armed_q & ~dbg_run_i;
    assign armed_d = armed_q | dbg_run_i;

    // Next-state and counter logic; the hold request wins over everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (hold) begin
                    state_d = ST_HELD;
                end else if (sw_rst_req_i) begin
                    state_d = ST_STRETCH;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_STRETCH: begin
                if (hold) begin
                    state_d = ST_HELD;
                end else if (sw_rst_req_i) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HELD: begin
                // Software requests are ignored here. Only the bridge can
                // release the channel, and the release always goes through a
                // full-width reset pulse.
                if (dbg_run_i) begin
                    state_d = ST_STRETCH;
                    cnt_d   = CNT_LOAD;
                end
            end
            default: begin
                state_d = ST_HELD;
                cnt_d   = CNT_LOAD;
            end
        endcase
    end

    // State, counter and arm registers. Reset aborts any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RST_ST;
            cnt_q   <= CNT_LOAD;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    // Outputs decode registered state only, so no input reaches them combinationally.
    assign rst_cpu_o = (state_q != ST_RUN);
    assign stretch_o = (state_q == ST_STRETCH);
    assign armed_o   = armed_q;

endmodule

// Top: NUM_CH fully independent channel instances.
module cpu_rst_ctrl #(
    parameter int NUM_CH     = 1,
    parameter int RST_CYCLES = 16,
    parameter bit BOOT_RUN   = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] dbg_run_i,
    input  logic [NUM_CH-1:0] sw_rst_req_i,
    output logic [NUM_CH-1:0] rst_cpu_o,
    output logic [NUM_CH-1:0] armed_o,
    output logic [NUM_CH-1:0] stretch_o
);

    // The counter must hold RST_CYCLES-1. Keep at least one bit so that
    // RST_CYCLES=1 still elaborates.
    localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    // One channel instance per CPU; the channels share no state.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        cpu_rst_ctrl_ch #(
            .RST_CYCLES (RST_CYCLES),
            .BOOT_RUN   (BOOT_RUN),
            .CW         (CW)
        ) u_ch (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .dbg_run_i    (dbg_run_i[g]),
            .sw_rst_req_i (sw_rst_req_i[g]),
            .rst_cpu_o    (rst_cpu_o[g]),
            .armed_o      (armed_o[g]),
            .stretch_o    (stretch_o[g])
        );
    end

endmodule
